dalu_exec_ctrl: RTL

- Execute-stage controller sitting directly upstream of the 8-bit ALU.
- Accepts register-to-register instructions over a valid/ready handshake and holds a small register file.
- Drives the ALU A/B/op inputs from that register file.
- Captures the ALU out/zero results and writes them back into the register file and a sticky zero flag.

---
 rtl/dalu_pkg.sv | 29 ++
 rtl/dalu_regfile.sv | 38 +++
 rtl/dalu_exec_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dalu_pkg.sv
// Shared opcode, state and width definitions for the 8-bit ALU execute controller.
package dalu_pkg;

  localparam int unsigned DALU_DATA_W = 8;
  localparam int unsigned OP_W        = 4;

  localparam logic [OP_W-1:0] OP_OR   = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd3;
  localparam logic [OP_W-1:0] OP_NOT  = 4'd4;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd5;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd6;
  localparam logic [OP_W-1:0] OP_PASS = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  // Opcodes outside 1..7 retire without touching architectural state.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_OR, OP_AND, OP_XOR, OP_NOT, OP_ADD, OP_SHL, OP_PASS: is_legal_op = 1'b1;
      default:                                               is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dalu_regfile.sv
// General register file: two operand read ports, one debug read port, one synchronous write port.
module dalu_regfile
  import dalu_pkg::*;
#(
  parameter int unsigned DATA_W = DALU_DATA_W,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [IDX_W-1:0]  ra_a_i,
  output logic [DATA_W-1:0] rd_a_o,
  input  logic [IDX_W-1:0]  ra_b_i,
  output logic [DATA_W-1:0] rd_b_o,
  input  logic [IDX_W-1:0]  dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] mem_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rd_a_o     = mem_q[ra_a_i];
  assign rd_b_o     = mem_q[ra_b_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/dalu_exec_ctrl.sv
// Execute-stage controller: sequences IDLE -> EXEC -> WB around an external 8-bit ALU.
// Define DALU_EXEC_CTRL_BYPASS_EN to accept in WB with a writeback-to-operand bypass.
module dalu_exec_ctrl
  import dalu_pkg::*;
#(
  parameter int unsigned DATA_W = DALU_DATA_W,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [IDX_W-1:0]  instr_rd,
  input  logic [IDX_W-1:0]  instr_ra,
  input  logic [IDX_W-1:0]  instr_rb,
  input  logic              instr_use_imm,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              done,
  output logic              illegal_op,
  output logic              zero_flag,
  input  logic [IDX_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [IDX_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              res_zero_q, res_zero_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic              zero_q, zero_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;

  logic              accept_c;
  logic              wb_legal_c;
  logic [DATA_W-1:0] rf_a_c, rf_b_c;
  logic [DATA_W-1:0] src_a_c, src_b_c;

  dalu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (wb_legal_c),
    .wa_i       (rd_q),
    .wd_i       (res_q),
    .ra_a_i     (instr_ra),
    .rd_a_o     (rf_a_c),
    .ra_b_i     (instr_rb),
    .rd_b_o     (rf_b_c),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  assign accept_c   = instr_valid && ready_q;
  assign wb_legal_c = (state_q == WB) && is_legal_op(op_q);

  // Operands are captured at acceptance; the regfile cannot change before EXEC
  // except through the WB write happening on that same edge.
`ifdef DALU_EXEC_CTRL_BYPASS_EN
  assign src_a_c = (wb_legal_c && (instr_ra == rd_q)) ? res_q : rf_a_c;
  assign src_b_c = (wb_legal_c && (instr_rb == rd_q)) ? res_q : rf_b_c;
`else
  assign src_a_c = rf_a_c;
  assign src_b_c = rf_b_c;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      res_q      <= '0;
      res_zero_q <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      zero_q     <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      res_q      <= res_d;
      res_zero_q <= res_zero_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      zero_q     <= zero_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    res_d      = res_q;
    res_zero_d = res_zero_q;
    zero_d     = zero_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;

    case (state_q)
      IDLE: begin
        if (accept_c) state_d = EXEC;
      end
      EXEC: begin
        state_d    = WB;
        res_d      = alu_out;
        res_zero_d = alu_zero;
      end
      WB: begin
        state_d = IDLE;
        if (wb_legal_c) zero_d = res_zero_q;
`ifdef DALU_EXEC_CTRL_BYPASS_EN
        if (accept_c) state_d = EXEC;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (accept_c) begin
      op_d    = instr_op;
      rd_d    = instr_rd;
      alu_a_d = src_a_c;
      alu_b_d = instr_use_imm ? instr_imm : src_b_c;
    end

    // Registered outputs are computed from the upcoming state so they align with it.
    alu_op_d  = (state_d == EXEC) ? op_d : '0;
    done_d    = (state_d == WB);
    illegal_d = (state_d == WB) && !is_legal_op(op_d);
    ready_d   = (state_d == IDLE);
`ifdef DALU_EXEC_CTRL_BYPASS_EN
    if (state_d == WB) ready_d = 1'b1;
`endif
  end

  assign instr_ready = ready_q;
  assign done        = done_q;
  assign illegal_op  = illegal_q;
  assign zero_flag   = zero_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;

endmodule
